// File: rtl/ppu_ri_pkg.sv
// Shared constants and types for the PPU CPU register interface.
package ppu_ri_pkg;

  localparam logic [2:0] SEL_CTRL     = 3'd0;
  localparam logic [2:0] SEL_MASK     = 3'd1;
  localparam logic [2:0] SEL_STATUS   = 3'd2;
  localparam logic [2:0] SEL_OAM_ADDR = 3'd3;
  localparam logic [2:0] SEL_OAM_DATA = 3'd4;
  localparam logic [2:0] SEL_SCROLL   = 3'd5;
  localparam logic [2:0] SEL_ADDR     = 3'd6;
  localparam logic [2:0] SEL_DATA     = 3'd7;

  localparam logic [5:0] PRAM_PAGE = 6'h3F;

  typedef enum logic {RD_IDLE, RD_WAIT} rd_state_e;

  // Loopy t layout: {fv[2:0], v, h, vt[4:0], ht[4:0]}
  localparam int T_HT_LSB = 0;
  localparam int T_VT_LSB = 5;
  localparam int T_H_BIT  = 10;
  localparam int T_V_BIT  = 11;
  localparam int T_FV_LSB = 12;

endpackage

// File: rtl/ppu_ri_open_bus.sv
// Open-bus latch: holds the last byte driven on the CPU data bus and
// clears it after DECAY_CYCLES clocks without a refresh (0 = never).
module ppu_ri_open_bus #(
  parameter int DECAY_CYCLES = 30000000,
  parameter int DECAY_W      = (DECAY_CYCLES > 0) ? $clog2(DECAY_CYCLES + 1) : 1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       load_in,
  input  logic [7:0] load_d_in,
  output logic [7:0] bus_out
);

  logic [7:0]         bus_q, bus_d;
  logic [DECAY_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    bus_d = bus_q;
    cnt_d = cnt_q;
    if (load_in) begin
      bus_d = load_d_in;
      cnt_d = '0;
    end else if (DECAY_CYCLES > 0) begin
      if (cnt_q == DECAY_W'(DECAY_CYCLES - 1)) bus_d = 8'h00;
      else                                      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    // NOTE: state is updated with non-blocking assignments so all flops sample together.
    if (rst_in) begin
      bus_q <= 8'h00;
      cnt_q <= '0;
    end else begin
      bus_q <= bus_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus_out = bus_q;

endmodule

// File: rtl/ppu_ri_ext.sv
// PPU $2000-$2007 CPU register interface with open-bus decay and a
// req/ack handshake for refilling the $2007 read buffer.
module ppu_ri_ext
  import ppu_ri_pkg::*;
#(
  parameter int VRAM_AW      = 14,
  parameter int DECAY_CYCLES = 30000000
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [2:0]         sel_in,
  input  logic               ncs_in,
  input  logic               r_nw_in,
  input  logic [7:0]         cpu_d_in,
  output logic [7:0]         cpu_d_out,
  input  logic [VRAM_AW-1:0] vram_a_in,
  output logic               vram_rd_req_out,
  output logic [VRAM_AW-1:0] vram_rd_a_out,
  input  logic               vram_rd_ack_in,
  input  logic [7:0]         vram_d_in,
  input  logic [5:0]         pram_d_in,
  output logic [7:0]         vram_d_out,
  output logic               vram_wr_out,
  output logic               pram_wr_out,
  input  logic               vblank_in,
  input  logic [7:0]         spr_ram_d_in,
  input  logic               spr_overflow_in,
  input  logic               spr_pri_col_in,
  output logic [7:0]         spr_ram_a_out,
  output logic [7:0]         spr_ram_d_out,
  output logic               spr_ram_wr_out,
  output logic [7:0]         ppuctrl_out,
  output logic [7:0]         ppumask_out,
  output logic [14:0]        t_out,
  output logic [2:0]         x_out,
  output logic               upd_cntrs_out,
  output logic               inc_addr_out,
  output logic               vblank_out
);

  localparam int DECAY_W = (DECAY_CYCLES > 0) ? $clog2(DECAY_CYCLES + 1) : 1;

  rd_state_e          state_q, state_d;
  logic               ncs_q, vblank_in_q, vblank_q, vblank_d, w_q, w_d;
  logic [7:0]         ppuctrl_q, ppuctrl_d, ppumask_q, ppumask_d;
  logic [14:0]        t_q, t_d;
  logic [2:0]         x_q, x_d;
  logic [7:0]         oam_ptr_q, oam_ptr_d, spr_d_q, spr_d_d, vram_d_q, vram_d_d;
  logic               spr_wr_q, spr_wr_d, vram_wr_q, vram_wr_d, pram_wr_q, pram_wr_d;
  logic               inc_addr_q, inc_addr_d, upd_q, upd_d, req_q, req_d;
  logic [7:0]         rd_data_q, rd_data_d, rd_buf_q, rd_buf_d;
  logic [VRAM_AW-1:0] rd_a_q, rd_a_d;

  logic       access, rd_acc, wr_acc, pram_hit, vbl_rise;
  logic [7:0] bus, rd_byte;

  ppu_ri_open_bus #(.DECAY_CYCLES(DECAY_CYCLES), .DECAY_W(DECAY_W)) u_open_bus (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .load_in   (access),
    .load_d_in (r_nw_in ? rd_byte : cpu_d_in),
    .bus_out   (bus)
  );

  always_comb begin
    access   = ncs_q & ~ncs_in;
    rd_acc   = access & r_nw_in;
    wr_acc   = access & ~r_nw_in;
    pram_hit = (vram_a_in[13:8] == PRAM_PAGE);
    vbl_rise = vblank_in & ~vblank_in_q;

    case (sel_in)
      SEL_STATUS:   rd_byte = {vblank_q | vbl_rise, spr_pri_col_in, spr_overflow_in, bus[4:0]};
      SEL_OAM_DATA: rd_byte = spr_ram_d_in;
      SEL_DATA:     rd_byte = pram_hit ? {bus[7:6], pram_d_in} : rd_buf_q;
      default:      rd_byte = bus;
    endcase

    state_d    = state_q;
    w_d        = w_q;
    ppuctrl_d  = ppuctrl_q;
    ppumask_d  = ppumask_q;
    t_d        = t_q;
    x_d        = x_q;
    oam_ptr_d  = spr_wr_q ? oam_ptr_q + 8'd1 : oam_ptr_q;
    spr_d_d    = spr_d_q;
    vram_d_d   = vram_d_q;
    rd_buf_d   = rd_buf_q;
    rd_a_d     = rd_a_q;
    rd_data_d  = rd_acc ? rd_byte : rd_data_q;
    spr_wr_d   = 1'b0;
    vram_wr_d  = 1'b0;
    pram_wr_d  = 1'b0;
    inc_addr_d = 1'b0;
    upd_d      = 1'b0;
    vblank_d   = vblank_q | vbl_rise;

    // Ack data lands first so a coincident $2007 read can still re-arm WAIT.
    if (state_q == RD_WAIT && vram_rd_ack_in) begin
      rd_buf_d = vram_d_in;
      state_d  = RD_IDLE;
    end

    if (rd_acc && sel_in == SEL_STATUS) begin
      vblank_d = 1'b0;
      w_d      = 1'b0;
    end
    if (rd_acc && sel_in == SEL_DATA) begin
      state_d    = RD_WAIT;
      rd_a_d     = vram_a_in;
      inc_addr_d = 1'b1;
    end

    if (wr_acc) begin
      case (sel_in)
        SEL_CTRL: begin
          ppuctrl_d             = cpu_d_in;
          t_d[T_V_BIT:T_H_BIT]  = cpu_d_in[1:0];
        end
        SEL_MASK:     ppumask_d = cpu_d_in;
        SEL_OAM_ADDR: oam_ptr_d = cpu_d_in;
        SEL_OAM_DATA: begin
          spr_wr_d = 1'b1;
          spr_d_d  = cpu_d_in;
        end
        SEL_SCROLL: begin
          w_d = ~w_q;
          if (!w_q) begin
            t_d[T_HT_LSB +: 5] = cpu_d_in[7:3];
            x_d                = cpu_d_in[2:0];
          end else begin
            t_d[T_FV_LSB +: 3] = cpu_d_in[2:0];
            t_d[T_VT_LSB +: 5] = cpu_d_in[7:3];
          end
        end
        SEL_ADDR: begin
          w_d = ~w_q;
          if (!w_q) begin
            t_d[13:8] = cpu_d_in[5:0];
            t_d[14]   = 1'b0;
          end else begin
            t_d[7:0] = cpu_d_in;
            upd_d    = 1'b1;
          end
        end
        default: begin
          vram_d_d   = cpu_d_in;
          pram_wr_d  = pram_hit;
          vram_wr_d  = ~pram_hit;
          inc_addr_d = 1'b1;
        end
      endcase
    end

    if (!vblank_in) vblank_d = 1'b0;
    req_d = (state_d == RD_WAIT);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= RD_IDLE;
      ncs_q       <= 1'b1;
      vblank_in_q <= 1'b0;
      vblank_q    <= 1'b0;
      w_q         <= 1'b0;
      ppuctrl_q   <= 8'h00;
      ppumask_q   <= 8'h00;
      t_q         <= 15'h0000;
      x_q         <= 3'h0;
      oam_ptr_q   <= 8'h00;
      spr_d_q     <= 8'h00;
      vram_d_q    <= 8'h00;
      spr_wr_q    <= 1'b0;
      vram_wr_q   <= 1'b0;
      pram_wr_q   <= 1'b0;
      inc_addr_q  <= 1'b0;
      upd_q       <= 1'b0;
      req_q       <= 1'b0;
      rd_data_q   <= 8'h00;
      rd_buf_q    <= 8'h00;
      rd_a_q      <= '0;
    end else begin
      state_q     <= state_d;
      ncs_q       <= ncs_in;
      vblank_in_q <= vblank_in;
      vblank_q    <= vblank_d;
      w_q         <= w_d;
      ppuctrl_q   <= ppuctrl_d;
      ppumask_q   <= ppumask_d;
      t_q         <= t_d;
      x_q         <= x_d;
      oam_ptr_q   <= oam_ptr_d;
      spr_d_q     <= spr_d_d;
      vram_d_q    <= vram_d_d;
      spr_wr_q    <= spr_wr_d;
      vram_wr_q   <= vram_wr_d;
      pram_wr_q   <= pram_wr_d;
      inc_addr_q  <= inc_addr_d;
      upd_q       <= upd_d;
      req_q       <= req_d;
      rd_data_q   <= rd_data_d;
      rd_buf_q    <= rd_buf_d;
      rd_a_q      <= rd_a_d;
    end
  end

  assign cpu_d_out       = (~ncs_in & r_nw_in) ? rd_data_q : 8'h00;
  assign vram_rd_req_out = req_q;
  assign vram_rd_a_out   = rd_a_q;
  assign vram_d_out      = vram_d_q;
  assign vram_wr_out     = vram_wr_q;
  assign pram_wr_out     = pram_wr_q;
  assign spr_ram_a_out   = oam_ptr_q;
  assign spr_ram_d_out   = spr_d_q;
  assign spr_ram_wr_out  = spr_wr_q;
  assign ppuctrl_out     = ppuctrl_q;
  assign ppumask_out     = ppumask_q;
  assign t_out           = t_q;
  assign x_out           = x_q;
  assign upd_cntrs_out   = upd_q;
  assign inc_addr_out    = inc_addr_q;
  assign vblank_out      = vblank_q;

endmodule

// File: tb/tb_ppu_ri_ext.sv
// Self-checking bench for ppu_ri_ext: CPU read data is scored through
// an expected/observed queue pair drained at the end of each scenario.
module tb_ppu_ri_ext;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [2:0]  sel_in = 3'd0;
  logic        ncs_in = 1'b1;
  logic        r_nw_in = 1'b1;
  logic [7:0]  cpu_d_in = 8'h00;
  logic [7:0]  cpu_d_out;
  logic [13:0] vram_a_in = 14'h0000;
  logic        vram_rd_req_out;
  logic [13:0] vram_rd_a_out;
  logic        vram_rd_ack_in = 1'b0;
  logic [7:0]  vram_d_in = 8'h00;
  logic [5:0]  pram_d_in = 6'h00;
  logic [7:0]  vram_d_out;
  logic        vram_wr_out, pram_wr_out;
  logic        vblank_in = 1'b0;
  logic [7:0]  spr_ram_d_in = 8'h00;
  logic        spr_overflow_in = 1'b0;
  logic        spr_pri_col_in = 1'b0;
  logic [7:0]  spr_ram_a_out, spr_ram_d_out;
  logic        spr_ram_wr_out;
  logic [7:0]  ppuctrl_out, ppumask_out;
  logic [14:0] t_out;
  logic [2:0]  x_out;
  logic        upd_cntrs_out, inc_addr_out, vblank_out;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];

  logic       s_upd, s_upd2, s_inc, s_vwr, s_pwr, s_swr;
  logic [7:0] s_sa, s_sd, s_vd;

  ppu_ri_ext #(.VRAM_AW(14), .DECAY_CYCLES(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .sel_in(sel_in), .ncs_in(ncs_in),
    .r_nw_in(r_nw_in), .cpu_d_in(cpu_d_in), .cpu_d_out(cpu_d_out),
    .vram_a_in(vram_a_in), .vram_rd_req_out(vram_rd_req_out),
    .vram_rd_a_out(vram_rd_a_out), .vram_rd_ack_in(vram_rd_ack_in),
    .vram_d_in(vram_d_in), .pram_d_in(pram_d_in), .vram_d_out(vram_d_out),
    .vram_wr_out(vram_wr_out), .pram_wr_out(pram_wr_out), .vblank_in(vblank_in),
    .spr_ram_d_in(spr_ram_d_in), .spr_overflow_in(spr_overflow_in),
    .spr_pri_col_in(spr_pri_col_in), .spr_ram_a_out(spr_ram_a_out),
    .spr_ram_d_out(spr_ram_d_out), .spr_ram_wr_out(spr_ram_wr_out),
    .ppuctrl_out(ppuctrl_out), .ppumask_out(ppumask_out), .t_out(t_out),
    .x_out(x_out), .upd_cntrs_out(upd_cntrs_out), .inc_addr_out(inc_addr_out),
    .vblank_out(vblank_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One CPU cycle: ncs low for one clock (decoded on its falling edge), then high.
  task automatic cpu_access(input logic [2:0] sel, input logic rnw, input logic [7:0] d);
    @(negedge clk_in);
    sel_in = sel; r_nw_in = rnw; cpu_d_in = d; ncs_in = 1'b0;
    @(negedge clk_in);
    if (rnw) obs_q.push_back(cpu_d_out);
    s_upd = upd_cntrs_out; s_inc = inc_addr_out; s_vwr = vram_wr_out;
    s_pwr = pram_wr_out;   s_swr = spr_ram_wr_out; s_sa = spr_ram_a_out;
    s_sd  = spr_ram_d_out; s_vd  = vram_d_out;
    ncs_in = 1'b1; r_nw_in = 1'b1;
    @(negedge clk_in);
    s_upd2 = upd_cntrs_out;
  endtask

  task automatic ack_pending(input logic [7:0] d);
    bit done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk_in);
      if (vram_rd_req_out) begin
        vram_d_in = d; vram_rd_ack_in = 1'b1;
        @(negedge clk_in);
        vram_rd_ack_in = 1'b0;
        done = 1'b1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL ack_wait: req never seen, got 0 required 1");
    end
  endtask

  task automatic test_reset;
    logic [7:0] e, o;
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    checks++;
    if ({ppuctrl_out, ppumask_out, t_out, x_out, upd_cntrs_out, inc_addr_out, vblank_out,
         vram_rd_req_out, vram_wr_out, pram_wr_out, spr_ram_wr_out, spr_ram_a_out,
         spr_ram_d_out, vram_d_out, vram_rd_a_out, cpu_d_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got t=%h ctrl=%h mask=%h req=%b, required all zero",
               t_out, ppuctrl_out, ppumask_out, vram_rd_req_out);
    end
    rst_in = 1'b0;
    exp_q.push_back(8'h00);
    cpu_access(3'd0, 1'b1, 8'h00);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      if (o !== e) begin errors++; $display("FAIL reset_read: got %h required %h", o, e); end
    end
    obs_q.delete();
  endtask

  task automatic test_addr_write;
    cpu_access(3'd6, 1'b0, 8'h21);
    checks++;
    if (t_out !== 15'h2100 || s_upd !== 1'b0) begin
      errors++; $display("FAIL addr_hi: got t=%h upd=%b required 2100 0", t_out, s_upd);
    end
    cpu_access(3'd6, 1'b0, 8'h08);
    checks++;
    if (t_out !== 15'h2108) begin
      errors++; $display("FAIL addr_lo: got t=%h required 2108", t_out);
    end
    checks++;
    if ({s_upd, s_upd2} !== 2'b10) begin
      errors++; $display("FAIL upd_pulse: got %b required 10", {s_upd, s_upd2});
    end
  endtask

  task automatic test_scroll_ctrl;
    cpu_access(3'd5, 1'b0, 8'h7D);
    checks++;
    if (t_out !== 15'h210F || x_out !== 3'h5) begin
      errors++; $display("FAIL scroll_x: got t=%h x=%h required 210f 5", t_out, x_out);
    end
    cpu_access(3'd5, 1'b0, 8'h5E);
    checks++;
    if (t_out !== 15'h616F) begin
      errors++; $display("FAIL scroll_y: got t=%h required 616f", t_out);
    end
    cpu_access(3'd0, 1'b0, 8'h83);
    cpu_access(3'd1, 1'b0, 8'h1E);
    checks++;
    if (ppuctrl_out !== 8'h83 || ppumask_out !== 8'h1E || t_out !== 15'h6D6F) begin
      errors++;
      $display("FAIL ctrl_mask: got ctrl=%h mask=%h t=%h required 83 1e 6d6f",
               ppuctrl_out, ppumask_out, t_out);
    end
  endtask

  task automatic test_delayed_read;
    logic [7:0] e, o;
    vram_a_in = 14'h2000;
    cpu_access(3'd6, 1'b0, 8'h20);
    cpu_access(3'd6, 1'b0, 8'h00);
    checks++;
    if (t_out !== 15'h2000) begin
      errors++; $display("FAIL addr_2000: got t=%h required 2000", t_out);
    end
    exp_q.push_back(8'h00);
    @(negedge clk_in);
    sel_in = 3'd7; r_nw_in = 1'b1; ncs_in = 1'b0;
    @(negedge clk_in);
    obs_q.push_back(cpu_d_out);
    checks++;
    if (inc_addr_out !== 1'b1) begin
      errors++; $display("FAIL rd_inc: got %b required 1", inc_addr_out);
    end
    ncs_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (vram_rd_req_out !== 1'b1 || vram_rd_a_out !== 14'h2000) begin
        errors++;
        $display("FAIL req_hold[%0d]: got req=%b a=%h required 1 2000", i, vram_rd_req_out, vram_rd_a_out);
      end
      if (i == 1) begin sel_in = 3'd7; r_nw_in = 1'b0; cpu_d_in = 8'h5A; ncs_in = 1'b0; end
      if (i == 2) begin
        checks++;
        if (vram_wr_out !== 1'b1 || vram_d_out !== 8'h5A) begin
          errors++; $display("FAIL wr_in_wait: got wr=%b d=%h required 1 5a", vram_wr_out, vram_d_out);
        end
        ncs_in = 1'b1; r_nw_in = 1'b1;
      end
      if (i == 4) begin vram_rd_ack_in = 1'b1; vram_d_in = 8'hA5; end
      @(negedge clk_in);
    end
    vram_rd_ack_in = 1'b0;
    checks++;
    if (vram_rd_req_out !== 1'b0) begin
      errors++; $display("FAIL req_drop: got %b required 0", vram_rd_req_out);
    end
    exp_q.push_back(8'hA5);
    cpu_access(3'd7, 1'b1, 8'h00);
    ack_pending(8'h3C);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      if (o !== e) begin errors++; $display("FAIL buffered_read: got %h required %h", o, e); end
    end
    obs_q.delete();
  endtask

  task automatic test_palette_read;
    logic [7:0] e, o;
    vram_a_in = 14'h3F01; pram_d_in = 6'h2A;
    cpu_access(3'd3, 1'b0, 8'hC0);
    exp_q.push_back(8'hEA);
    cpu_access(3'd7, 1'b1, 8'h00);
    checks++;
    if (vram_rd_req_out !== 1'b1 || vram_rd_a_out !== 14'h3F01) begin
      errors++; $display("FAIL pal_req: got req=%b a=%h required 1 3f01", vram_rd_req_out, vram_rd_a_out);
    end
    ack_pending(8'h66);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      if (o !== e) begin errors++; $display("FAIL palette_read: got %h required %h", o, e); end
    end
    obs_q.delete();
  endtask

  task automatic test_vram_write;
    vram_a_in = 14'h2005;
    cpu_access(3'd7, 1'b0, 8'h5A);
    checks++;
    if ({s_vwr, s_pwr, s_inc, s_vd} !== {3'b101, 8'h5A}) begin
      errors++; $display("FAIL vram_wr: got %b%b%b %h required 101 5a", s_vwr, s_pwr, s_inc, s_vd);
    end
    vram_a_in = 14'h3F10;
    cpu_access(3'd7, 1'b0, 8'h11);
    checks++;
    if ({s_vwr, s_pwr, s_inc, s_vd} !== {3'b011, 8'h11}) begin
      errors++; $display("FAIL pram_wr: got %b%b%b %h required 011 11", s_vwr, s_pwr, s_inc, s_vd);
    end
  endtask

  task automatic test_status;
    logic [7:0] e, o;
    spr_pri_col_in = 1'b1; spr_overflow_in = 1'b0;
    @(negedge clk_in);
    vblank_in = 1'b1;
    cpu_access(3'd3, 1'b0, 8'h1B);
    checks++;
    if (vblank_out !== 1'b1) begin
      errors++; $display("FAIL vblank_set: got %b required 1", vblank_out);
    end
    exp_q.push_back(8'hDB);
    cpu_access(3'd2, 1'b1, 8'h00);
    exp_q.push_back(8'h5B);
    cpu_access(3'd2, 1'b1, 8'h00);
    @(negedge clk_in);
    vblank_in = 1'b0;
    @(negedge clk_in);
    // Rising edge of vblank_in coincides with the $2002 access edge.
    vblank_in = 1'b1; sel_in = 3'd2; r_nw_in = 1'b1; ncs_in = 1'b0;
    exp_q.push_back(8'hDB);
    @(negedge clk_in);
    obs_q.push_back(cpu_d_out);
    ncs_in = 1'b1;
    checks++;
    if (vblank_out !== 1'b0) begin
      errors++; $display("FAIL vblank_race: got %b required 0", vblank_out);
    end
    exp_q.push_back(8'h5B);
    cpu_access(3'd2, 1'b1, 8'h00);
    vblank_in = 1'b0; spr_pri_col_in = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      if (o !== e) begin errors++; $display("FAIL status_read: got %h required %h", o, e); end
    end
    obs_q.delete();
  endtask

  task automatic test_oam;
    logic [7:0] e, o;
    cpu_access(3'd3, 1'b0, 8'hFF);
    cpu_access(3'd4, 1'b0, 8'h11);
    checks++;
    if ({s_swr, s_sa, s_sd} !== {1'b1, 8'hFF, 8'h11}) begin
      errors++; $display("FAIL oam_wr0: got %b %h %h required 1 ff 11", s_swr, s_sa, s_sd);
    end
    cpu_access(3'd4, 1'b0, 8'h22);
    checks++;
    if ({s_swr, s_sa, s_sd} !== {1'b1, 8'h00, 8'h22}) begin
      errors++; $display("FAIL oam_wrap: got %b %h %h required 1 00 22", s_swr, s_sa, s_sd);
    end
    checks++;
    if (spr_ram_a_out !== 8'h01) begin
      errors++; $display("FAIL oam_ptr: got %h required 01", spr_ram_a_out);
    end
    spr_ram_d_in = 8'h9C;
    exp_q.push_back(8'h9C);
    cpu_access(3'd4, 1'b1, 8'h00);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      if (o !== e) begin errors++; $display("FAIL oam_read: got %h required %h", o, e); end
    end
    obs_q.delete();
  endtask

  task automatic test_decay;
    logic [7:0] e, o;
    cpu_access(3'd0, 1'b0, 8'hFF);
    repeat (3) @(negedge clk_in);
    exp_q.push_back(8'hFF);
    cpu_access(3'd1, 1'b1, 8'h00);
    repeat (20) @(negedge clk_in);
    exp_q.push_back(8'h00);
    cpu_access(3'd1, 1'b1, 8'h00);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      if (o !== e) begin errors++; $display("FAIL decay_read: got %h required %h", o, e); end
    end
    obs_q.delete();
  endtask

  task automatic test_reset_in_wait;
    logic [7:0] e, o;
    vram_a_in = 14'h2123;
    exp_q.push_back(8'h66);
    cpu_access(3'd7, 1'b1, 8'h00);
    checks++;
    if (vram_rd_req_out !== 1'b1 || vram_rd_a_out !== 14'h2123) begin
      errors++; $display("FAIL wait_entry: got req=%b a=%h required 1 2123", vram_rd_req_out, vram_rd_a_out);
    end
    rst_in = 1'b1;
    @(negedge clk_in);
    checks++;
    if ({ppuctrl_out, ppumask_out, t_out, x_out, vram_rd_req_out, vram_rd_a_out,
         spr_ram_a_out, vram_d_out, cpu_d_out} !== '0) begin
      errors++;
      $display("FAIL rst_in_wait: got req=%b ctrl=%h t=%h required all zero",
               vram_rd_req_out, ppuctrl_out, t_out);
    end
    rst_in = 1'b0; vram_d_in = 8'h77; vram_rd_ack_in = 1'b1;
    @(negedge clk_in);
    vram_rd_ack_in = 1'b0;
    checks++;
    if (vram_rd_req_out !== 1'b0) begin
      errors++; $display("FAIL late_ack_req: got %b required 0", vram_rd_req_out);
    end
    exp_q.push_back(8'h00);
    cpu_access(3'd7, 1'b1, 8'h00);
    ack_pending(8'h12);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      if (o !== e) begin errors++; $display("FAIL late_ack_read: got %h required %h", o, e); end
    end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_addr_write();
    test_scroll_ctrl();
    test_delayed_read();
    test_palette_read();
    test_vram_write();
    test_status();
    test_oam();
    test_decay();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
